// File: rtl/key_command_encoder_pkg.sv
// Shared types and constants for the player-command producer.
// Command encoding matches what the game FSM consumes.
package key_command_encoder_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_HIT   = 2'd1,
    CMD_STAND = 2'd2
  } game_command_t;

  localparam int HIT_KEY   = 0;
  localparam int STAND_KEY = 1;

  localparam logic KEY_STATE_UP   = 1'b1;
  localparam logic KEY_STATE_DOWN = 1'b0;

endpackage

// File: rtl/key_command_encoder_if.sv
// One-deep valid/ready command channel from the key encoder to the game FSM.
interface key_command_encoder_if;
  import key_command_encoder_pkg::*;

  game_command_t cmd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dropped;

  modport master (output cmd, output cmd_valid, output cmd_dropped, input  cmd_ready);
  modport slave  (input  cmd, input  cmd_valid, input  cmd_dropped, output cmd_ready);

endinterface

// File: rtl/key_command_encoder_debouncer.sv
// Per-key synchronizer, debounce counter, stable level and registered press pulse.
module key_debouncer
  import key_command_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_down,
  output logic press
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        press_d  = (sync2_q == KEY_STATE_DOWN);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so all flops update together.
    if (reset) begin
      sync1_q  <= KEY_STATE_UP;
      sync2_q  <= KEY_STATE_UP;
      stable_q <= KEY_STATE_UP;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign key_down = (stable_q == KEY_STATE_DOWN);
  assign press    = press_q;

endmodule

// File: rtl/key_command_encoder.sv
// Turns debounced HIT/STAND presses into one-deep valid/ready commands.
// STAND wins a same-edge tie; anything that cannot be loaded is reported via cmd_dropped.
module key_command_encoder
  import key_command_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             keys,
  output logic [1:0]             key_down,
  key_command_encoder_if.master  cmd_if
);

  logic [1:0] press;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (keys[k]),
      .key_down (key_down[k]),
      .press    (press[k])
    );
  end

  game_command_t cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_dropped_q, cmd_dropped_d;
  logic          accept, loadable;

  always_comb begin
    accept        = cmd_valid_q && cmd_if.cmd_ready;
    loadable      = !cmd_valid_q || accept;
    cmd_d         = cmd_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_dropped_d = 1'b0;
    if (press[STAND_KEY] && loadable) begin
      cmd_d         = CMD_STAND;
      cmd_valid_d   = 1'b1;
      cmd_dropped_d = press[HIT_KEY];
    end else if (press[HIT_KEY] && loadable) begin
      cmd_d       = CMD_HIT;
      cmd_valid_d = 1'b1;
    end else if (|press) begin
      // Both-key collisions still produce a single drop pulse.
      cmd_dropped_d = 1'b1;
    end else if (accept) begin
      cmd_d       = CMD_NONE;
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q         <= CMD_NONE;
      cmd_valid_q   <= 1'b0;
      cmd_dropped_q <= 1'b0;
    end else begin
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_dropped_q <= cmd_dropped_d;
    end
  end

  assign cmd_if.cmd         = cmd_q;
  assign cmd_if.cmd_valid   = cmd_valid_q;
  assign cmd_if.cmd_dropped = cmd_dropped_q;

endmodule

// File: tb/tb_key_command_encoder.sv
// Directed and randomized bench for key_command_encoder against a sample-window model.
module tb_key_command_encoder;
  import key_command_encoder_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] keys;
  logic [1:0] key_down;

  key_command_encoder_if cmd_if ();

  key_command_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .keys     (keys),
    .key_down (key_down),
    .cmd_if   (cmd_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: a key's synchronized sample is its raw value two edges late; the stable level
  // flips once D consecutive synchronized samples disagree with it.
  int  m_cmd;
  bit  m_valid, m_drop;
  bit  m_down [2];
  bit  m_ev   [2];
  bit  dly    [2][$];
  bit  win    [2][$];
  bit  model_ok = 1'b0;

  always @(posedge clk) begin
    bit accept, loadable, s;
    if (reset) begin
      m_cmd = 0; m_valid = 0; m_drop = 0;
      for (int k = 0; k < 2; k++) begin
        m_down[k] = 0; m_ev[k] = 0;
        dly[k] = '{1'b1, 1'b1};
        win[k] = {};
      end
      model_ok = 1'b1;
    end else if (model_ok) begin
      accept   = m_valid && cmd_if.cmd_ready;
      loadable = !m_valid || accept;
      m_drop   = 0;
      if (m_ev[1] && loadable) begin
        m_cmd = 2; m_valid = 1; m_drop = m_ev[0];
      end else if (m_ev[0] && loadable) begin
        m_cmd = 1; m_valid = 1;
      end else if (m_ev[0] || m_ev[1]) begin
        m_drop = 1;
      end else if (accept) begin
        m_cmd = 0; m_valid = 0;
      end
      for (int k = 0; k < 2; k++) begin
        s = dly[k].pop_front();
        dly[k].push_back(keys[k]);
        m_ev[k] = 0;
        if (s == !m_down[k]) win[k] = {};
        else win[k].push_back(s);
        if (win[k].size() == D) begin
          m_down[k] = !s;
          m_ev[k]   = !s;
          win[k]    = {};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cmd",         32'(cmd_if.cmd),         32'(m_cmd));
      check("cmd_valid",   32'(cmd_if.cmd_valid),   32'(m_valid));
      check("cmd_dropped", 32'(cmd_if.cmd_dropped), 32'(m_drop));
      check("key_down",    32'(key_down),           32'({m_down[1], m_down[0]}));
    end
  end

  task automatic accept_and_release();
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    keys = 2'b11;
    repeat (10) tick();
  endtask

  initial begin
    reset = 1'b1;
    keys  = 2'b11;
    cmd_if.cmd_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid",   32'(cmd_if.cmd_valid),   32'd0);
    check("rst_cmd",     32'(cmd_if.cmd),         32'(CMD_NONE));
    check("rst_keydown", 32'(key_down),           32'd0);
    check("rst_dropped", 32'(cmd_if.cmd_dropped), 32'd0);
    reset = 1'b0;
    tick();

    // HIT held: command appears after edge 6, key_down one edge earlier.
    keys = 2'b10;
    repeat (6) tick();
    check("hit_valid_e5",   32'(cmd_if.cmd_valid), 32'd0);
    check("hit_keydown_e5", 32'(key_down),         32'b01);
    tick();
    check("hit_valid_e6", 32'(cmd_if.cmd_valid), 32'd1);
    check("hit_cmd_e6",   32'(cmd_if.cmd),       32'(CMD_HIT));
    repeat (13) tick();
    check("hit_held_valid", 32'(cmd_if.cmd_valid), 32'd1);
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    check("hit_accepted", 32'(cmd_if.cmd_valid), 32'd0);
    keys = 2'b11;
    repeat (10) tick();

    // STAND bounces shorter than D, then a steady press.
    for (int b = 0; b < 4; b++) begin
      keys = (b % 2 == 0) ? 2'b01 : 2'b11;
      repeat (3) tick();
    end
    check("bounce_no_cmd", 32'(cmd_if.cmd_valid), 32'd0);
    keys = 2'b01;
    repeat (6) tick();
    check("stand_valid_e5", 32'(cmd_if.cmd_valid), 32'd0);
    tick();
    check("stand_valid_e6", 32'(cmd_if.cmd_valid), 32'd1);
    check("stand_cmd_e6",   32'(cmd_if.cmd),       32'(CMD_STAND));
    accept_and_release();

    // Both keys on the same edge: STAND loads, HIT dropped.
    keys = 2'b00;
    repeat (6) tick();
    check("both_drop_e5", 32'(cmd_if.cmd_dropped), 32'd0);
    tick();
    check("both_cmd",     32'(cmd_if.cmd),         32'(CMD_STAND));
    check("both_drop",    32'(cmd_if.cmd_dropped), 32'd1);
    check("both_keydown", 32'(key_down),           32'b11);
    tick();
    check("both_drop_once", 32'(cmd_if.cmd_dropped), 32'd0);
    accept_and_release();

    // HIT pending, STAND arrives without ready: dropped.
    keys = 2'b10;
    repeat (7) tick();
    check("pend_hit", 32'(cmd_if.cmd), 32'(CMD_HIT));
    keys = 2'b00;
    repeat (7) tick();
    check("pend_keep_hit", 32'(cmd_if.cmd),         32'(CMD_HIT));
    check("pend_drop",     32'(cmd_if.cmd_dropped), 32'd1);
    tick();
    check("pend_drop_once", 32'(cmd_if.cmd_dropped), 32'd0);
    keys = 2'b10;
    repeat (10) tick();
    // Same again but ready on the event edge: STAND replaces HIT.
    keys = 2'b00;
    repeat (6) tick();
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    check("ready_cmd",   32'(cmd_if.cmd),         32'(CMD_STAND));
    check("ready_valid", 32'(cmd_if.cmd_valid),   32'd1);
    check("ready_nodrop",32'(cmd_if.cmd_dropped), 32'd0);
    accept_and_release();

    // Reset with HIT held and pending; held key re-presses after reset.
    keys = 2'b10;
    repeat (7) tick();
    check("prerst_valid", 32'(cmd_if.cmd_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_valid",   32'(cmd_if.cmd_valid), 32'd0);
    check("midrst_cmd",     32'(cmd_if.cmd),       32'(CMD_NONE));
    check("midrst_keydown", 32'(key_down),         32'b00);
    reset = 1'b0;
    repeat (6) tick();
    check("postrst_valid_e5", 32'(cmd_if.cmd_valid), 32'd0);
    tick();
    check("postrst_valid_e6", 32'(cmd_if.cmd_valid), 32'd1);
    check("postrst_cmd_e6",   32'(cmd_if.cmd),       32'(CMD_HIT));
    accept_and_release();

    // Randomized keys, ready and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) keys = 2'($urandom_range(0, 3));
      cmd_if.cmd_ready = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    keys = 2'b11;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
